// File: rtl/frame_parity_checker_if.sv
// Serial frame bus for frame_parity_checker: bit stream and clear in, frame status out.
interface frame_parity_checker_if #(
   parameter int unsigned CNT_W = 8
);
   logic             bit_valid;
   logic             input_bit;
   logic             clear_cnt;
   logic             frame_done;
   logic             Saida;
   logic [CNT_W-1:0] err_count;
   logic             busy;
   logic             frame_abort;

   modport master (
      output bit_valid, input_bit, clear_cnt,
      input  frame_done, Saida, err_count, busy, frame_abort
   );

   modport slave (
      input  bit_valid, input_bit, clear_cnt,
      output frame_done, Saida, err_count, busy, frame_abort
   );
endinterface

// File: rtl/frame_parity_checker.sv
// Serial even/odd parity checker with saturating bad-frame counter.
// Optional partial-frame timeout abort enabled by defining FRAME_TIMEOUT_EN.
module frame_parity_checker #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned ODD_PARITY  = 0,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input logic                   clk,
   input logic                   reset_n,
   frame_parity_checker_if.slave bus
);
   localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);
   localparam logic        ODD    = (ODD_PARITY != 0);

   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

   state_t            state, state_nxt;
   logic              acc, acc_nxt;
   logic [BCNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic              done_q, done_nxt;
   logic              saida_q, saida_nxt;
   logic              err_inc;
   logic [CNT_W-1:0]  errcnt_q, errcnt_nxt;

`ifdef FRAME_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] tcnt, tcnt_nxt, tcnt_inc;
   logic            abort_q, abort_nxt;
`endif

   assign cnt_inc = cnt + 1'b1;
`ifdef FRAME_TIMEOUT_EN
   assign tcnt_inc = tcnt + 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      saida_nxt = saida_q;
      err_inc   = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      tcnt_nxt  = '0;
      abort_nxt = 1'b0;
`endif
      if (bus.bit_valid) begin
         case (state)
            IDLE: begin
               acc_nxt   = bus.input_bit;
               cnt_nxt   = BCNT_W'(1);
               state_nxt = (DATA_BITS == 1) ? PARITY : DATA;
            end
            DATA: begin
               acc_nxt = acc ^ bus.input_bit;
               cnt_nxt = cnt_inc;
               if (cnt_inc == BCNT_W'(DATA_BITS))
                  state_nxt = PARITY;
            end
            PARITY: begin
               saida_nxt = acc ^ bus.input_bit ^ ODD;
               err_inc   = saida_nxt;
               done_nxt  = 1'b1;
               acc_nxt   = 1'b0;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
`ifdef FRAME_TIMEOUT_EN
      // Idle gaps inside a frame are counted; the Nth consecutive one drops the frame.
      else if (state != IDLE) begin
         if (tcnt_inc == TO_W'(TIMEOUT_CYC)) begin
            state_nxt = IDLE;
            acc_nxt   = 1'b0;
            cnt_nxt   = '0;
            abort_nxt = 1'b1;
         end else begin
            tcnt_nxt = tcnt_inc;
         end
      end
`endif

      errcnt_nxt = errcnt_q;
      if (bus.clear_cnt)
         errcnt_nxt = '0;
      else if (err_inc && (errcnt_q != '1))
         errcnt_nxt = errcnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         acc      <= 1'b0;
         cnt      <= '0;
         done_q   <= 1'b0;
         saida_q  <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         cnt      <= cnt_nxt;
         done_q   <= done_nxt;
         saida_q  <= saida_nxt;
         errcnt_q <= errcnt_nxt;
      end
   end

`ifdef FRAME_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tcnt    <= '0;
         abort_q <= 1'b0;
      end else begin
         tcnt    <= tcnt_nxt;
         abort_q <= abort_nxt;
      end
   end
   assign bus.frame_abort = abort_q;
`else
   assign bus.frame_abort = 1'b0;
`endif

   assign bus.frame_done = done_q;
   assign bus.Saida      = saida_q;
   assign bus.err_count  = errcnt_q;
   assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_frame_parity_checker.sv
// Scoreboard bench: even, odd and 2-bit-counter checkers share one serial stream.
// Timeout abort scenario is exercised when FRAME_TIMEOUT_EN is defined.
module tb_frame_parity_checker;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, bv, ib, clr;

   frame_parity_checker_if #(.CNT_W(8)) if_even ();
   frame_parity_checker_if #(.CNT_W(8)) if_odd ();
   frame_parity_checker_if #(.CNT_W(2)) if_sat ();

   assign if_even.bit_valid = bv;
   assign if_even.input_bit = ib;
   assign if_even.clear_cnt = clr;
   assign if_odd.bit_valid  = bv;
   assign if_odd.input_bit  = ib;
   assign if_odd.clear_cnt  = clr;
   assign if_sat.bit_valid  = bv;
   assign if_sat.input_bit  = ib;
   assign if_sat.clear_cnt  = clr;

   frame_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0), .CNT_W(8), .TIMEOUT_CYC(16))
      u_even (.clk(clk), .reset_n(reset_n), .bus(if_even.slave));
   frame_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1), .CNT_W(8), .TIMEOUT_CYC(16))
      u_odd  (.clk(clk), .reset_n(reset_n), .bus(if_odd.slave));
   frame_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0), .CNT_W(2), .TIMEOUT_CYC(16))
      u_sat  (.clk(clk), .reset_n(reset_n), .bus(if_sat.slave));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int pos, idle;
   bit acc;
   bit sb_q[$];
   int cnt_even, cnt_odd, cnt_sat;
   bit last_even, last_odd;
   bit exp_done, exp_abort;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      pos = 0; idle = 0; acc = 1'b0;
      sb_q.delete();
      cnt_even = 0; cnt_odd = 0; cnt_sat = 0;
      last_even = 1'b0; last_odd = 1'b0;
   endtask

   task automatic check_outputs();
      bit err;
      chk("done_even", {7'd0, if_even.frame_done}, {7'd0, exp_done});
      chk("done_odd",  {7'd0, if_odd.frame_done},  {7'd0, exp_done});
      chk("done_sat",  {7'd0, if_sat.frame_done},  {7'd0, exp_done});
      if (if_even.frame_done === 1'b1) begin
         chk("sb_nonempty", {7'd0, (sb_q.size() != 0)}, 8'd1);
         if (sb_q.size() != 0) begin
            err       = sb_q.pop_front();
            last_even = err;
            last_odd  = !err;
         end
      end
      chk("saida_even", {7'd0, if_even.Saida}, {7'd0, last_even});
      chk("saida_odd",  {7'd0, if_odd.Saida},  {7'd0, last_odd});
      chk("cnt_even", if_even.err_count, 8'(cnt_even));
      chk("cnt_odd",  if_odd.err_count,  8'(cnt_odd));
      chk("cnt_sat",  {6'd0, if_sat.err_count}, 8'(cnt_sat));
      chk("busy", {7'd0, if_even.busy}, {7'd0, (pos != 0)});
      chk("abort", {7'd0, if_even.frame_abort}, {7'd0, exp_abort});
   endtask

   // One clock: drive inputs, advance the model, then check after the edge.
   task automatic step(input bit v, input bit b, input bit c);
      bit err;
      bv = v; ib = b; clr = c;
      exp_done = 1'b0; exp_abort = 1'b0; err = 1'b0;
      if (v) begin
         idle = 0;
         acc  = acc ^ b;
         pos++;
         if (pos == 9) begin
            exp_done = 1'b1;
            err      = acc;
            sb_q.push_back(acc);
            pos = 0; acc = 1'b0;
         end
      end else if (pos != 0) begin
`ifdef FRAME_TIMEOUT_EN
         idle++;
         if (idle == 16) begin
            exp_abort = 1'b1;
            pos = 0; acc = 1'b0; idle = 0;
         end
`endif
      end else begin
         idle = 0;
      end
      if (c) begin
         cnt_even = 0; cnt_odd = 0; cnt_sat = 0;
      end else if (exp_done) begin
         if (err  && cnt_even < 255) cnt_even++;
         if (!err && cnt_odd  < 255) cnt_odd++;
         if (err  && cnt_sat  < 3)   cnt_sat++;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic send_frame(input logic [7:0] data, input bit par, input int gap_max,
                             input bit clr_on_par);
      logic [8:0] bits;
      bits = {data, par};
      for (int i = 8; i >= 0; i--) begin
         if (gap_max > 0) begin
            int g;
            g = $urandom_range(gap_max, 0);
            for (int k = 0; k < g; k++) step(1'b0, 1'b0, 1'b0);
         end
         step(1'b1, bits[i], (i == 0) ? clr_on_par : 1'b0);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bv = 1'b1; ib = 1'b1; clr = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_clear();
      exp_done = 1'b0; exp_abort = 1'b0;
      check_outputs();
   endtask

   initial begin
      logic [7:0] d;
      model_clear();
      reset_n = 1'b0; bv = 1'b0; ib = 1'b0; clr = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // Good even frame, then same data with wrong parity
      send_frame(8'b1011_0000, 1'b1, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      send_frame(8'b1011_0000, 1'b0, 0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // Gapped frame, then back-to-back random frames
      send_frame(8'b1011_0000, 1'b1, 5, 1'b0);
      for (int f = 0; f < 6; f++) begin
         d = 8'($urandom);
         send_frame(d, 1'($urandom), 0, 1'b0);
      end
      for (int f = 0; f < 4; f++) begin
         d = 8'($urandom);
         send_frame(d, 1'($urandom), 5, 1'b0);
      end

      // Saturation of the 2-bit counter, then clear racing an increment
      for (int f = 0; f < 5; f++) send_frame(8'b0000_0001, 1'b0, 0, 1'b0);
      send_frame(8'b0000_0001, 1'b0, 0, 1'b1);
      send_frame(8'b0000_0011, 1'b1, 0, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      // Reset mid-frame, then a fresh frame
      send_frame(8'b1110_0000, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
      do_reset();
      send_frame(8'b1011_0000, 1'b0, 0, 1'b0);
      send_frame(8'b1011_0000, 1'b1, 0, 1'b0);

      // Partial frame left idle: aborts with timeout, otherwise waits
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0, 1'b0);
      while (pos != 0) step(1'b1, 1'($urandom), 1'b0);
      send_frame(8'b0101_0101, 1'b0, 0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
